// File: rtl/inv_key_schedule.sv
// AES-128 round-key generator for a decryption datapath: expands a cipher key
// into 11 round keys (one per clock) and presents them in descending order.
// Ports: clk, rst (async, active-high), key_load + cipher_key[127:0] start an
// expansion; key_req advances the presented key; round_key[127:0],
// round_idx[3:0], keys_ready and busy report the presented key and status.
// Option: define KEY_SCHED_FWD_EN to add input fwd for ascending order.

module key_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] x,
    input logic [7:0] y
  );
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x4, x8, x16, x32, x64, x128;
  logic [7:0] inv;

  // Multiplicative inverse as a^254 (0 maps to 0), then the affine map.
  always_comb begin
    x2   = gf_mul(a, a);
    x4   = gf_mul(x2, x2);
    x8   = gf_mul(x4, x4);
    x16  = gf_mul(x8, x8);
    x32  = gf_mul(x16, x16);
    x64  = gf_mul(x32, x32);
    x128 = gf_mul(x64, x64);
    inv  = gf_mul(gf_mul(gf_mul(x2, x4), gf_mul(x8, x16)),
                  gf_mul(gf_mul(x32, x64), x128));
    s = inv
      ^ {inv[6:0], inv[7]}
      ^ {inv[5:0], inv[7:6]}
      ^ {inv[4:0], inv[7:5]}
      ^ {inv[3:0], inv[7:4]}
      ^ 8'h63;
  end

endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         key_req,
`ifdef KEY_SCHED_FWD_EN
  input  logic         fwd,
`endif
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         keys_ready,
  output logic         busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [3:0]   ptr_q, ptr_d;
  logic [3:0]   wr_q, wr_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         busy_q, busy_d;
  logic         rdy_q, rdy_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   ridx_q, ridx_d;

  logic [127:0] kbuf_q [0:10];
  logic         kbuf_we;
  logic [3:0]   kbuf_wa;
  logic [127:0] kbuf_wd;

  logic         asc;
  logic [3:0]   ptr_nxt;

`ifdef KEY_SCHED_FWD_EN
  assign asc = fwd;
`else
  assign asc = 1'b0;
`endif

  // One expansion round from the previously written key.
  logic [127:0] cur;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, temp;
  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] nk;

  assign cur  = kbuf_q[wr_q - 4'd1];
  assign w0   = cur[127:96];
  assign w1   = cur[95:64];
  assign w2   = cur[63:32];
  assign w3   = cur[31:0];
  assign rot  = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    key_sbox u_sbox (
      .a (rot[8*g +: 8]),
      .s (sub[8*g +: 8])
    );
  end

  assign temp = sub ^ {rcon_q, 24'h000000};
  assign w4   = w0 ^ temp;
  assign w5   = w4 ^ w1;
  assign w6   = w5 ^ w2;
  assign w7   = w6 ^ w3;
  assign nk   = {w4, w5, w6, w7};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_d    = wr_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    rkey_d  = rkey_q;
    ridx_d  = ridx_q;
    kbuf_we = 1'b0;
    kbuf_wa = wr_q;
    kbuf_wd = nk;
    ptr_nxt = ptr_q;

    if (asc) ptr_nxt = (ptr_q == 4'd10) ? 4'd0 : ptr_q + 4'd1;
    else     ptr_nxt = (ptr_q == 4'd0) ? 4'd10 : ptr_q - 4'd1;

    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (key_load) begin
          // Capture wins over key_req; the stale key set is withdrawn.
          state_d = ST_EXPAND;
          kbuf_we = 1'b1;
          kbuf_wa = 4'd0;
          kbuf_wd = cipher_key;
          wr_d    = 4'd1;
          rcon_d  = 8'h01;
          ptr_d   = 4'd10;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          rkey_d  = '0;
          ridx_d  = '0;
        end else if (state_q == ST_READY && key_req) begin
          ptr_d  = ptr_nxt;
          ridx_d = ptr_nxt;
          rkey_d = kbuf_q[ptr_nxt];
        end
      end
      ST_EXPAND: begin
        kbuf_we = 1'b1;
        wr_d    = wr_q + 4'd1;
        rcon_d  = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (wr_q == 4'd10) begin
          // Round 10 is still in flight; forward it to the output directly.
          state_d = ST_READY;
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          ptr_d   = asc ? 4'd0 : 4'd10;
          ridx_d  = asc ? 4'd0 : 4'd10;
          rkey_d  = asc ? kbuf_q[0] : nk;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        rdy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 4'd10;
      wr_q    <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      rkey_q  <= '0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_q    <= wr_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      rkey_q  <= rkey_d;
      ridx_q  <= ridx_d;
    end
  end

  // Key storage needs no reset: it is only read after a full expansion.
  always_ff @(posedge clk) begin
    if (kbuf_we) kbuf_q[kbuf_wa] <= kbuf_wd;
  end

  assign round_key  = rkey_q;
  assign round_idx  = ridx_q;
  assign keys_ready = rdy_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for inv_key_schedule: stimulus queues expected round
// keys, a negedge monitor pops and compares each newly presented key.

module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         key_req;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         keys_ready;
  logic         busy;
`ifdef KEY_SCHED_FWD_EN
  logic         fwd;
`endif

  inv_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .key_req    (key_req),
`ifdef KEY_SCHED_FWD_EN
    .fwd        (fwd),
`endif
    .round_key  (round_key),
    .round_idx  (round_idx),
    .keys_ready (keys_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t sb[$];

  logic [127:0] rk [0:10];
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int n_chk = 0;
  int n_fail = 0;
  int m_chk = 0;
  int m_fail = 0;

  // Monitor: a key is "presented" when keys_ready rises or after an
  // accepted key_req; otherwise a ready output must hold still.
  logic         prev_ready = 1'b0;
  logic         prev_adv = 1'b0;
  logic [127:0] last_key = '0;
  logic [3:0]   last_idx = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b0;
      prev_adv   = 1'b0;
    end else begin
      if (keys_ready && (!prev_ready || prev_adv)) begin
        m_chk++;
        if (sb.size() == 0) begin
          m_fail++;
          $display("FAIL present_unexpected: got idx=%0d key=%h, none required",
                   round_idx, round_key);
        end else begin
          e = sb.pop_front();
          if (round_idx !== e.idx || round_key !== e.key) begin
            m_fail++;
            $display("FAIL present: got idx=%0d key=%h, required idx=%0d key=%h",
                     round_idx, round_key, e.idx, e.key);
          end
        end
      end else if (keys_ready && prev_ready) begin
        m_chk++;
        if (round_idx !== last_idx || round_key !== last_key) begin
          m_fail++;
          $display("FAIL stable: got idx=%0d key=%h, required idx=%0d key=%h",
                   round_idx, round_key, last_idx, last_key);
        end
      end
      prev_ready = keys_ready;
      prev_adv   = keys_ready && key_req && !key_load;
      last_key   = round_key;
      last_idx   = round_idx;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ok,
                     input logic [127:0] got, input logic [127:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic [127:0] key);
    exp_t e;
    e.idx = idx;
    e.key = key;
    sb.push_back(e);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 40) begin
      step();
      c++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic do_load(input logic [127:0] k, input logic req,
                         input logic intf);
    int n;
    int c;
    cipher_key = k;
    key_load = 1'b1;
    key_req = req;
    step();
    key_load = 1'b0;
    key_req = 1'b0;
    chk("load_start", !keys_ready && busy,
        {126'd0, keys_ready, busy}, 128'd1);
    n = 0;
    c = 0;
    while (!keys_ready && c < 40) begin
      if (busy) n++;
      c++;
      if (intf && n == 5) begin
        cipher_key = ~k;
        key_load = 1'b1;
        key_req = 1'b1;
      end
      step();
      key_load = 1'b0;
      key_req = 1'b0;
    end
    chk("busy_cycles", n == 10, 128'(n), 128'd10);
    drain();
  endtask

  task automatic req_pulse();
    key_req = 1'b1;
    step();
    key_req = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rk[0]  = K1;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1;
    key_load = 1'b0;
    key_req = 1'b0;
    cipher_key = '0;
`ifdef KEY_SCHED_FWD_EN
    fwd = 1'b0;
`endif
    step();
    step();
    chk("reset_key", round_key == 0, round_key, 128'd0);
    chk("reset_flags", !keys_ready && !busy && round_idx == 0,
        {122'd0, keys_ready, busy, round_idx}, 128'd0);
    rst = 1'b0;

    // key_req in IDLE has no effect
    key_req = 1'b1;
    step();
    step();
    key_req = 1'b0;
    chk("idle_req", !keys_ready && !busy,
        {126'd0, keys_ready, busy}, 128'd0);

    // Load K1 with a competing load and key_req mid-expansion
    push(4'd10, rk[10]);
    do_load(K1, 1'b0, 1'b1);

    // Descend 9..0, then wrap to 10
    for (int i = 9; i >= 0; i--) begin
      push(4'(i), rk[i]);
      req_pulse();
    end
    push(4'd10, rk[10]);
    req_pulse();

    // Second key, then load+req in the same cycle
    push(4'd10, K2_R10);
    do_load(K2, 1'b0, 1'b0);
    push(4'd10, rk[10]);
    do_load(K1, 1'b1, 1'b0);
    push(4'd9, rk[9]);
    req_pulse();

    // Reset between edges in the middle of an expansion
    cipher_key = K2;
    key_load = 1'b1;
    step();
    key_load = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_key", round_key == 0, round_key, 128'd0);
    chk("rst_mid_flags", !keys_ready && !busy && round_idx == 0,
        {122'd0, keys_ready, busy, round_idx}, 128'd0);
    #1;
    rst = 1'b0;
    step();
    step();
    chk("post_rst_idle", !keys_ready && !busy,
        {126'd0, keys_ready, busy}, 128'd0);
    push(4'd10, rk[10]);
    do_load(K1, 1'b0, 1'b0);
    push(4'd9, rk[9]);
    req_pulse();

`ifdef KEY_SCHED_FWD_EN
    fwd = 1'b1;
    push(4'd0, K1);
    do_load(K1, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      push(4'(i), rk[i]);
      req_pulse();
    end
    push(4'd0, K1);
    req_pulse();
    fwd = 1'b0;
`endif

    step();
    step();
    n_chk = n_chk + m_chk;
    n_fail = n_fail + m_fail;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
